// File: rtl/stopwatch_mode_ctrl_pkg.sv
// Shared types and defaults for the stopwatch mode controller.
// The optional DOWN_HALT_EN build macro is consumed by stopwatch_mode_ctrl.
package stopwatch_pkg;

  localparam int CNT_W                   = 14;
  localparam int TICK_CYCLES_DEFAULT     = 1_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int CNT_MAX                 = 9999;

  localparam int BTN_MODE = 0;
  localparam int BTN_RUN  = 1;
  localparam int BTN_CLR  = 2;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_UP      = 2'b01,
    MODE_DOWN    = 2'b10,
    MODE_SW_READ = 2'b11
  } mode_t;

  typedef struct packed {
    mode_t      mode;
    logic       run;
    logic [2:0] btn_level;
  } ctrl_state_t;

  // IDLE is never a successor; it is reachable only through reset.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_IDLE:    n = MODE_UP;
      MODE_UP:      n = MODE_DOWN;
      MODE_DOWN:    n = MODE_SW_READ;
      default:      n = MODE_UP;
    endcase
    return n;
  endfunction

  function automatic logic is_counting(input mode_t m);
    return (m == MODE_UP) || (m == MODE_DOWN);
  endfunction

endpackage

// File: rtl/stopwatch_mode_ctrl_if.sv
// Board-side signal bundle between the mode controller and the counter/FND datapath.
interface stopwatch_mode_ctrl_if;
  import stopwatch_pkg::*;

  logic [2:0]       btn;
  logic [7:0]       sw;
  logic [CNT_W-1:0] cnt_value;
  // No valid/ready pairing: each cnt_* is a one-cycle strobe that the datapath
  // must act on in the cycle it is high; at most one strobe is high per cycle.
  logic             cnt_inc;
  logic             cnt_dec;
  logic             cnt_clr;
  logic             cnt_load;
  logic [CNT_W-1:0] seg_data;
  logic [15:0]      led;

  modport master (
    input  btn, sw, cnt_value,
    output cnt_inc, cnt_dec, cnt_clr, cnt_load, seg_data, led
  );

  modport slave (
    output btn, sw, cnt_value,
    input  cnt_inc, cnt_dec, cnt_clr, cnt_load, seg_data, led
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level counter and rising-edge press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] stable_cnt_q, stable_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // The counter runs only while the synced input disagrees with the accepted level.
  always_comb begin
    stable_cnt_d = '0;
    level_d      = level_q;
    press_d      = 1'b0;
    if (sync2_q != level_q) begin
      if (stable_cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        stable_cnt_d = stable_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_cnt_q <= stable_cnt_d;
      level_q      <= level_d;
      press_q      <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// Stopwatch sequencer: mode FSM, run/pause, 10 ms prescaler, counter commands, FND/LED muxes.
// Build macro DOWN_HALT_EN: a DOWN tick at cnt_value==0 pauses instead of issuing cnt_dec.
module stopwatch_mode_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYCLES     = TICK_CYCLES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  stopwatch_mode_ctrl_if.master bus,
  output ctrl_state_t           dbg_state
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [2:0] press;
  logic [2:0] btn_level;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(bus.btn[i]),
      .level  (btn_level[i]),
      .press  (press[i])
    );
  end

  mode_t            mode_q, mode_d;
  logic             run_q, run_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             clr_q, clr_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] seg_q, seg_d;
  logic [15:0]      led_q, led_d;

  always_comb begin
    mode_d  = mode_q;
    run_d   = run_q;
    presc_d = presc_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    clr_d   = 1'b0;
    load_d  = 1'b0;

    // Mode press takes priority: run and clear presses in the same cycle are dropped.
    if (press[BTN_MODE]) begin
      mode_d  = next_mode(mode_q);
      run_d   = 1'b0;
      presc_d = '0;
      if (mode_d == MODE_DOWN) load_d = 1'b1;
      else                     clr_d  = 1'b1;
    end else if (is_counting(mode_q)) begin
      if (press[BTN_RUN]) run_d = ~run_q;
      if (press[BTN_CLR]) begin
        presc_d = '0;
        if (mode_q == MODE_UP) clr_d  = 1'b1;
        else                   load_d = 1'b1;
      end else if (run_q) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (mode_q == MODE_UP) inc_d = 1'b1;
`ifdef DOWN_HALT_EN
          else if (bus.cnt_value == '0) run_d = 1'b0;
`endif
          else dec_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end

    case (mode_q)
      MODE_UP, MODE_DOWN: seg_d = bus.cnt_value;
      MODE_SW_READ:       seg_d = {{(CNT_W-8){1'b0}}, bus.sw};
      default:            seg_d = '0;
    endcase

    led_d = {mode_d, run_d, 13'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_IDLE;
      run_q   <= 1'b0;
      presc_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      clr_q   <= 1'b0;
      load_q  <= 1'b0;
      seg_q   <= '0;
      led_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      run_q   <= run_d;
      presc_q <= presc_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      clr_q   <= clr_d;
      load_q  <= load_d;
      seg_q   <= seg_d;
      led_q   <= led_d;
    end
  end

  assign bus.cnt_inc  = inc_q;
  assign bus.cnt_dec  = dec_q;
  assign bus.cnt_clr  = clr_q;
  assign bus.cnt_load = load_q;
  assign bus.seg_data = seg_q;
  assign bus.led      = led_q;

  assign dbg_state = '{mode: mode_q, run: run_q, btn_level: btn_level};

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Bench for stopwatch_mode_ctrl: directed scenarios plus random buttons,
// all checked every cycle against a behavioural model of the stopwatch rules.
module tb_stopwatch_mode_ctrl;
  import stopwatch_pkg::*;

  localparam int TICK = 10;
  localparam int DEB  = 4;

  localparam logic [3:0] C_INC  = 4'b1000;
  localparam logic [3:0] C_DEC  = 4'b0100;
  localparam logic [3:0] C_CLR  = 4'b0010;
  localparam logic [3:0] C_LOAD = 4'b0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  ctrl_state_t dbg_state;

  always #5 clk = ~clk;

  stopwatch_mode_ctrl_if bus_if ();

  stopwatch_mode_ctrl #(
    .TICK_CYCLES    (TICK),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode numbers follow the LED code: 0 idle, 1 up, 2 down, 3 switch readout
  int         m_mode, m_run, m_presc;
  bit         m_level[3];
  int         m_diff[3];
  bit         m_press[3];
  logic [2:0] m_hist[$];
  logic [3:0] e_cmd;
  logic [13:0] e_seg;
  logic [15:0] e_led;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_presc = 0;
    for (int b = 0; b < 3; b++) begin
      m_level[b] = 0; m_diff[b] = 0; m_press[b] = 0;
    end
    m_hist.delete();
    e_cmd = '0; e_seg = '0; e_led = '0;
  endtask

  // One clock edge of the stopwatch as the rules describe it.
  task automatic model_edge();
    int old_mode = m_mode;
    int old_run  = m_run;
    logic [2:0] synced;

    e_cmd = '0;
    if (m_press[0]) begin
      m_mode  = (m_mode == 3) ? 1 : m_mode + 1;
      m_run   = 0;
      m_presc = 0;
      e_cmd   = (m_mode == 2) ? C_LOAD : C_CLR;
    end else if (old_mode == 1 || old_mode == 2) begin
      if (m_press[1]) m_run = !m_run;
      if (m_press[2]) begin
        e_cmd   = (old_mode == 1) ? C_CLR : C_LOAD;
        m_presc = 0;
      end else if (old_run != 0) begin
        m_presc++;
        if (m_presc == TICK) begin
          m_presc = 0;
          if (old_mode == 1) e_cmd = C_INC;
          else begin
`ifdef DOWN_HALT_EN
            if (bus_if.cnt_value == 0) m_run = 0;
            else e_cmd = C_DEC;
`else
            e_cmd = C_DEC;
`endif
          end
        end
      end
    end

    if (old_mode == 1 || old_mode == 2) e_seg = bus_if.cnt_value;
    else if (old_mode == 3)             e_seg = {6'b0, bus_if.sw};
    else                                e_seg = '0;
    e_led = {2'(m_mode), 1'(m_run), 13'b0};

    // buttons seen two edges late, accepted after DEB consecutive disagreeing edges
    m_hist.push_back(bus_if.btn);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    synced = (m_hist.size() == 3) ? m_hist[0] : 3'b000;
    for (int b = 0; b < 3; b++) begin
      m_press[b] = 0;
      if (synced[b] != m_level[b]) begin
        m_diff[b]++;
        if (m_diff[b] == DEB) begin
          m_level[b] = synced[b];
          m_diff[b]  = 0;
          m_press[b] = synced[b];
        end
      end else begin
        m_diff[b] = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [3:0] cmd;
    @(posedge clk);
    model_edge();
    #1;
    cmd = {bus_if.cnt_inc, bus_if.cnt_dec, bus_if.cnt_clr, bus_if.cnt_load};
    check_eq("cmd",  {28'b0, cmd}, {28'b0, e_cmd});
    check_eq("seg",  {18'b0, bus_if.seg_data}, {18'b0, e_seg});
    check_eq("led",  {16'b0, bus_if.led}, {16'b0, e_led});
    check_eq("cmd_onehot", {31'b0, $countones(cmd) <= 1}, 32'd1);
    check_eq("dbg_mode", {30'b0, dbg_state.mode}, m_mode);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [2:0] mask);
    bus_if.btn = mask;
    idle(7);
    bus_if.btn = 3'b000;
    idle(7);
  endtask

  task automatic random_phase(input int n);
    int hold[3] = '{0, 0, 0};
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          bus_if.btn[b] = (b == BTN_RUN) ? 1'($urandom_range(0, 1))
                                         : ($urandom_range(0, 3) == 0);
          hold[b] = $urandom_range(1, 12);
        end
        hold[b]--;
      end
      bus_if.cnt_value = ($urandom_range(0, 3) == 0) ? 14'd0 : 14'($urandom_range(0, 9999));
      bus_if.sw        = 8'($urandom_range(0, 255));
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus_if.btn       = 3'b000;
    bus_if.sw        = 8'h00;
    bus_if.cnt_value = 14'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_led", {16'b0, bus_if.led}, 32'd0);
    check_eq("rst_seg", {18'b0, bus_if.seg_data}, 32'd0);
    check_eq("rst_cmd", {28'b0, bus_if.cnt_inc, bus_if.cnt_dec, bus_if.cnt_clr, bus_if.cnt_load}, 32'd0);
    reset = 1'b0;

    idle(50);                       // quiet after reset
    bus_if.cnt_value = 14'd123;
    press(3'b001);                  // IDLE -> UP, clr
    press(3'b010);                  // run
    idle(35);                       // inc every TICK
    bus_if.btn = 3'b010;            // 2-cycle glitch
    idle(2);
    bus_if.btn = 3'b000;
    idle(8);
    press(3'b001);                  // UP -> DOWN, load, paused
    idle(15);
    press(3'b010);                  // run in DOWN
    bus_if.cnt_value = 14'd0;       // tick at zero
    idle(25);
    bus_if.cnt_value = 14'd5;
    press(3'b001);                  // DOWN -> SW_READ
    press(3'b001);                  // SW_READ -> UP
    press(3'b101);                  // mode + clear together -> DOWN, load only
    press(3'b001);                  // SW_READ
    bus_if.sw = 8'hA5;
    idle(3);

    random_phase(2500);

    // asynchronous reset in mid-cycle, with the mode button held through it
    bus_if.btn = 3'b001;
    #3 reset = 1'b1;
    #1;
    check_eq("async_led", {16'b0, bus_if.led}, 32'd0);
    check_eq("async_seg", {18'b0, bus_if.seg_data}, 32'd0);
    check_eq("async_cmd", {28'b0, bus_if.cnt_inc, bus_if.cnt_dec, bus_if.cnt_clr, bus_if.cnt_load}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle(12);
    bus_if.btn = 3'b000;
    idle(10);

    random_phase(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
